// File: rtl/mem_bus_initiator_if.sv
// Request/response handshake and memory-bus control signals for mem_bus_initiator.
//
// The bidirectional data bus (mem_data) is not part of this interface: it is a
// plain inout port of the initiator so the tri-state net is declared and resolved
// in the parent, next to the responder that shares it.
//
// Signals:
//   req_valid/req_ready  request handshake (client -> initiator)
//   req_write            1 = write, 0 = read
//   req_addr, req_wdata  request address / write data
//   rsp_valid            1-cycle completion pulse
//   rsp_rdata, rsp_err   read data / readback-mismatch flag
//   mem_addr             registered bus address
//   mem_read, mem_write  level read / write strobes
//
// Modports: master = initiator view, slave = client-plus-responder view.
interface mem_bus_initiator_if #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 5
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [AWIDTH-1:0] req_addr;
  logic [DWIDTH-1:0] req_wdata;
  logic              rsp_valid;
  logic [DWIDTH-1:0] rsp_rdata;
  logic              rsp_err;
  logic [AWIDTH-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_addr, mem_read, mem_write
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_addr, mem_read, mem_write
  );
endinterface

// File: rtl/mem_bus_initiator.sv
// mem_bus_initiator: turns single valid/ready requests into read/write cycles on a
// shared tri-state memory bus and returns one rsp_valid pulse per transaction.
//
// Ports:
//   clk       in     single clock, rising edge
//   rst       in     asynchronous active-high reset
//   bus       master request/response handshake, mem_addr, mem_read, mem_write
//   mem_data  inout  shared data bus; driven only in write states, 'z otherwise
//
// Parameters: DWIDTH (data width), AWIDTH (address width),
//             RD_WAIT (cycles mem_read is held before sampling, >= 1).
//
// Optional feature: define MEM_BUS_INITIATOR_VERIFY_EN to read back every write
// (VRD state) and flag a mismatch on rsp_err. Without it rsp_err is tied low.
//
// Write: IDLE -> SETUP -> WSTB -> WHOLD -> IDLE            (rsp at T+4)
// Read : IDLE -> SETUP -> RSTB x RD_WAIT -> TURN -> IDLE   (rsp at T+3+RD_WAIT)
// Verify write: ... WHOLD -> VRD x RD_WAIT -> TURN -> IDLE (rsp at T+5+RD_WAIT)
module mem_bus_initiator #(
  parameter int DWIDTH  = 8,
  parameter int AWIDTH  = 5,
  parameter int RD_WAIT = 1
) (
  input  logic               clk,
  input  logic               rst,
  mem_bus_initiator_if.master bus,
  inout  wire  [DWIDTH-1:0]  mem_data
);

  generate
    if (RD_WAIT < 1) begin : g_bad_rd_wait
      $error("mem_bus_initiator: RD_WAIT must be >= 1");
    end
  endgenerate

  localparam int CW = (RD_WAIT < 1) ? 1 : $clog2(RD_WAIT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_WSTB  = 3'd2;
  localparam logic [2:0] S_WHOLD = 3'd3;
  localparam logic [2:0] S_RSTB  = 3'd4;
  localparam logic [2:0] S_TURN  = 3'd5;
`ifdef MEM_BUS_INITIATOR_VERIFY_EN
  localparam logic [2:0] S_VRD   = 3'd6;
`endif

  logic [2:0]        state_reg, state_next;
  logic [AWIDTH-1:0] addr_reg;
  logic [DWIDTH-1:0] wdata_reg;
  logic [DWIDTH-1:0] rdata_reg;
  logic              write_reg;
  logic              read_stb_reg;
  logic              write_stb_reg;
  logic              drive_reg;
  logic              ready_reg;
  logic              rsp_valid_reg;
  logic [CW-1:0]     cnt_reg;
  logic              accept;
  logic              cnt_last;
  logic              in_read_wait;

  // ready_reg is only ever high in IDLE, so it alone qualifies acceptance.
  assign accept   = ready_reg && bus.req_valid;
  assign cnt_last = (cnt_reg == '0);

`ifdef MEM_BUS_INITIATOR_VERIFY_EN
  logic err_reg;
  assign in_read_wait = (state_reg == S_RSTB) || (state_reg == S_VRD);
`else
  assign in_read_wait = (state_reg == S_RSTB);
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept) state_next = S_SETUP;
      S_SETUP: state_next = write_reg ? S_WSTB : S_RSTB;
      S_WSTB:  state_next = S_WHOLD;
`ifdef MEM_BUS_INITIATOR_VERIFY_EN
      S_WHOLD: state_next = S_VRD;
      S_VRD:   if (cnt_last) state_next = S_TURN;
`else
      S_WHOLD: state_next = S_IDLE;
`endif
      S_RSTB:  if (cnt_last) state_next = S_TURN;
      S_TURN:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Strobes, bus drive and ready are registered from state_next so they line up
  // exactly with the state they belong to and drop asynchronously on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      rdata_reg     <= '0;
      write_reg     <= 1'b0;
      read_stb_reg  <= 1'b0;
      write_stb_reg <= 1'b0;
      drive_reg     <= 1'b0;
      ready_reg     <= 1'b0;
      rsp_valid_reg <= 1'b0;
      cnt_reg       <= '0;
`ifdef MEM_BUS_INITIATOR_VERIFY_EN
      err_reg       <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      ready_reg     <= (state_next == S_IDLE);
      write_stb_reg <= (state_next == S_WSTB);
`ifdef MEM_BUS_INITIATOR_VERIFY_EN
      read_stb_reg  <= (state_next == S_RSTB) || (state_next == S_VRD);
`else
      read_stb_reg  <= (state_next == S_RSTB);
`endif
      // SETUP is only entered on accept, so req_write is the live request here.
      drive_reg     <= (state_next == S_WSTB) || (state_next == S_WHOLD) ||
                       ((state_next == S_SETUP) && bus.req_write);
      rsp_valid_reg <= (state_next == S_IDLE) && (state_reg != S_IDLE);

      if (accept) begin
        addr_reg  <= bus.req_addr;
        wdata_reg <= bus.req_wdata;
        write_reg <= bus.req_write;
      end

      // Load the wait counter in the state preceding a read window; it then
      // counts down to zero, which marks the sampling cycle.
      if ((state_reg == S_SETUP) || (state_reg == S_WHOLD)) begin
        cnt_reg <= CW'(RD_WAIT - 1);
      end else if (!cnt_last) begin
        cnt_reg <= cnt_reg - 1'b1;
      end

      if (in_read_wait && cnt_last) begin
        rdata_reg <= mem_data;
`ifdef MEM_BUS_INITIATOR_VERIFY_EN
        err_reg   <= (state_reg == S_VRD) && (mem_data != wdata_reg);
`endif
      end
    end
  end

  assign mem_data      = drive_reg ? wdata_reg : {DWIDTH{1'bz}};
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_read  = read_stb_reg;
  assign bus.mem_write = write_stb_reg;
  assign bus.req_ready = ready_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_rdata = rdata_reg;
`ifdef MEM_BUS_INITIATOR_VERIFY_EN
  assign bus.rsp_err   = err_reg;
`else
  assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_initiator.sv
// Directed bench for mem_bus_initiator: one DUT with RD_WAIT=1 and one with
// RD_WAIT=3, each with a behavioural memory responder on its tri-state bus.
module tb_mem_bus_initiator;

`ifdef MEM_BUS_INITIATOR_VERIFY_EN
  localparam int WR_LAT = 6;
`else
  localparam int WR_LAT = 4;
`endif
  localparam int RD_LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   wr_pulses = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_bus_initiator_if #(.DWIDTH(8), .AWIDTH(5)) if1 ();
  mem_bus_initiator_if #(.DWIDTH(8), .AWIDTH(5)) if3 ();
  wire [7:0] mem_data1;
  wire [7:0] mem_data3;

  mem_bus_initiator #(.DWIDTH(8), .AWIDTH(5), .RD_WAIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1), .mem_data(mem_data1));
  mem_bus_initiator #(.DWIDTH(8), .AWIDTH(5), .RD_WAIT(3)) u_dut3 (
    .clk(clk), .rst(rst), .bus(if3), .mem_data(mem_data3));

  // Responders: synchronous memory committing at a clock edge while mem_write is
  // high, combinational read drive while mem_read is high. stuck0 forces bit 0
  // of bus-1 memory reads to 0; probe drives bus 1 to test that it is released.
  logic [7:0] mem1 [0:31];
  logic [7:0] mem3 [0:31];
  logic       stuck0 = 1'b0;
  logic       probe_en = 1'b0;
  logic [7:0] probe_val = 8'h00;
  logic [7:0] mask1;
  logic [7:0] resp1;

  assign mask1 = stuck0 ? 8'hFE : 8'hFF;
  assign resp1 = mem1[if1.mem_addr] & mask1;
  assign mem_data1 = if1.mem_read ? resp1 : (probe_en ? probe_val : 8'bz);
  assign mem_data3 = if3.mem_read ? mem3[if3.mem_addr] : 8'bz;

  always @(posedge clk) if (if1.mem_write) mem1[if1.mem_addr] <= mem_data1;
  always @(posedge clk) if (if3.mem_write) mem3[if3.mem_addr] <= mem_data3;
  always @(posedge if1.mem_write) wr_pulses <= wr_pulses + 1;

  // Continuous bus invariants.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ((if1.mem_read && if1.mem_write) || (if3.mem_read && if3.mem_write)) begin
        failures++;
        $display("FAIL strobe_overlap t=%0t rd1=%b wr1=%b rd3=%b wr3=%b required no overlap",
                 $time, if1.mem_read, if1.mem_write, if3.mem_read, if3.mem_write);
      end
      checks++;
      if ((if1.req_ready && (if1.mem_read || if1.mem_write)) ||
          (if3.req_ready && (if3.mem_read || if3.mem_write))) begin
        failures++;
        $display("FAIL strobe_in_idle t=%0t required no strobe while req_ready", $time);
      end
      if (if1.mem_read) begin
        checks++;
        if (mem_data1 !== resp1) begin
          failures++;
          $display("FAIL bus1_contention t=%0t got=%h required=%h", $time, mem_data1, resp1);
        end
      end
      if (if3.mem_read) begin
        checks++;
        if (mem_data3 !== mem3[if3.mem_addr]) begin
          failures++;
          $display("FAIL bus3_contention t=%0t got=%h required=%h", $time, mem_data3,
                   mem3[if3.mem_addr]);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog t=%0t simulation did not finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction on bus 1 (sel=0) or bus 3 (sel=1). Returns latency from the
  // accept cycle to the rsp_valid cycle and leaves time in the rsp_valid cycle.
  task automatic do_txn(input bit sel, input bit wr, input logic [4:0] a,
                        input logic [7:0] d, output int lat, output logic [7:0] rdata,
                        output logic err, output int rd_hi);
    int t;
    bit acc;
    bit got;
    lat = -1; rdata = 8'h00; err = 1'b0; rd_hi = 0; t = 0; acc = 1'b0; got = 1'b0;
    if (sel) begin
      if3.req_write = wr; if3.req_addr = a; if3.req_wdata = d; if3.req_valid = 1'b1;
    end else begin
      if1.req_write = wr; if1.req_addr = a; if1.req_wdata = d; if1.req_valid = 1'b1;
    end
    for (int i = 0; i < 20 && !acc; i++) begin
      if (sel ? if3.req_ready : if1.req_ready) begin
        acc = 1'b1;
        t = cyc;
      end
      tick();
    end
    if1.req_valid = 1'b0;
    if3.req_valid = 1'b0;
    if (!acc) begin
      checks++; failures++;
      $display("FAIL accept_timeout bus=%0d addr=%0d got=no accept required=accept", sel, a);
    end else begin
      for (int i = 0; i < 20 && !got; i++) begin
        rd_hi += int'(sel ? if3.mem_read : if1.mem_read);
        if (sel ? if3.rsp_valid : if1.rsp_valid) begin
          got = 1'b1;
          lat = cyc - t;
          rdata = sel ? if3.rsp_rdata : if1.rsp_rdata;
          err = sel ? if3.rsp_err : if1.rsp_err;
        end else begin
          tick();
        end
      end
      if (!got) begin
        checks++; failures++;
        $display("FAIL rsp_timeout bus=%0d addr=%0d got=no rsp required=rsp", sel, a);
      end
    end
    $display("txn bus=%0d %s addr=%0d wdata=%h lat=%0d rdata=%h err=%b",
             sel ? 3 : 1, wr ? "WR" : "RD", a, d, lat, rdata, err);
  endtask

  task automatic test_write_read();
    int lat; logic [7:0] rd; logic err; int rh;
    do_txn(1'b0, 1'b1, 5'd5, 8'hA5, lat, rd, err, rh);
    checks++;
    if (lat !== WR_LAT) begin failures++; $display("FAIL wr_latency got=%0d required=%0d", lat, WR_LAT); end
    do_txn(1'b0, 1'b0, 5'd5, 8'h00, lat, rd, err, rh);
    checks++;
    if (lat !== RD_LAT) begin failures++; $display("FAIL rd_latency got=%0d required=%0d", lat, RD_LAT); end
    checks++;
    if (rd !== 8'hA5) begin failures++; $display("FAIL rd_data got=%h required=a5", rd); end
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL rd_err got=%b required=0", err); end
    checks++;
    if (rh !== 1) begin failures++; $display("FAIL rd_strobe_len got=%0d required=1", rh); end
  endtask

  task automatic test_idle_no_activity();
    if1.req_valid = 1'b0; if1.req_write = 1'b1; if1.req_addr = 5'd17; if1.req_wdata = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (if1.mem_addr !== 5'd5 || if1.mem_read !== 1'b0 || if1.mem_write !== 1'b0 ||
          if1.rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL idle_quiet addr=%0d rd=%b wr=%b rsp=%b required addr=5 all 0",
                 if1.mem_addr, if1.mem_read, if1.mem_write, if1.rsp_valid);
      end
    end
  endtask

  task automatic test_reset();
    if1.req_write = 1'b1; if1.req_addr = 5'd9; if1.req_wdata = 8'h3C; if1.req_valid = 1'b1;
    tick();
    if1.req_valid = 1'b0;
    tick(); tick();          // now in WHOLD: address and data driven
    #2 rst = 1'b1;
    #1;
    checks++;
    if (if1.mem_addr !== 5'd0 || if1.mem_read !== 1'b0 || if1.mem_write !== 1'b0) begin
      failures++;
      $display("FAIL reset_bus addr=%0d rd=%b wr=%b required 0/0/0",
               if1.mem_addr, if1.mem_read, if1.mem_write);
    end
    checks++;
    if (if1.rsp_valid !== 1'b0 || if1.rsp_rdata !== 8'h00 || if1.rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_rsp valid=%b rdata=%h err=%b required 0/00/0",
               if1.rsp_valid, if1.rsp_rdata, if1.rsp_err);
    end
    checks++;
    if (if1.req_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b required=0", if1.req_ready); end
    probe_val = 8'h5A; probe_en = 1'b1;
    #1;
    checks++;
    if (mem_data1 !== 8'h5A) begin failures++; $display("FAIL reset_bus_release got=%h required=5a", mem_data1); end
    probe_en = 1'b0;
    tick();
    checks++;
    if (if1.req_ready !== 1'b0) begin failures++; $display("FAIL ready_in_reset got=%b required=0", if1.req_ready); end
    #3 rst = 1'b0;
    #1;
    checks++;
    if (if1.req_ready !== 1'b0) begin failures++; $display("FAIL ready_at_release got=%b required=0", if1.req_ready); end
    tick();
    checks++;
    if (if1.req_ready !== 1'b1) begin failures++; $display("FAIL ready_after_release got=%b required=1", if1.req_ready); end
  endtask

  task automatic test_back_to_back();
    int acc [3]; int rsp [3]; int n; int nr; int p0; bit ok;
    int lat; logic [7:0] rd; logic err; int rh;
    n = 0; nr = 0; p0 = wr_pulses;
    acc = '{0, 0, 0}; rsp = '{0, 0, 0};
    if1.req_write = 1'b1; if1.req_addr = 5'd0; if1.req_wdata = 8'h10; if1.req_valid = 1'b1;
    for (int i = 0; i < 60 && nr < 3; i++) begin
      ok = if1.req_ready && if1.req_valid;
      if (if1.rsp_valid) begin rsp[nr] = cyc; nr++; end
      if (ok) begin acc[n] = cyc; n++; end
      if (nr < 3) tick();
      if (ok) begin
        if (n == 3) if1.req_valid = 1'b0;
        else begin if1.req_addr = 5'(n); if1.req_wdata = 8'h10 + 8'(n); end
      end
    end
    if1.req_valid = 1'b0;
    checks++;
    if (nr !== 3 || n !== 3) begin failures++; $display("FAIL b2b_count acc=%0d rsp=%0d required 3/3", n, nr); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rsp[i] - acc[i] !== WR_LAT) begin
        failures++;
        $display("FAIL b2b_latency idx=%0d got=%0d required=%0d", i, rsp[i] - acc[i], WR_LAT);
      end
      $display("txn bus=1 WR b2b idx=%0d accept=%0d rsp=%0d", i, acc[i], rsp[i]);
    end
    checks++;
    if (acc[2] - acc[1] !== WR_LAT || acc[1] - acc[0] !== WR_LAT) begin
      failures++;
      $display("FAIL b2b_spacing got=%0d,%0d required=%0d", acc[1] - acc[0], acc[2] - acc[1], WR_LAT);
    end
    checks++;
    if (wr_pulses - p0 !== 3) begin failures++; $display("FAIL b2b_pulses got=%0d required=3", wr_pulses - p0); end
    for (int i = 0; i < 3; i++) begin
      do_txn(1'b0, 1'b0, 5'(i), 8'h00, lat, rd, err, rh);
      checks++;
      if (rd !== 8'h10 + 8'(i)) begin
        failures++;
        $display("FAIL b2b_readback addr=%0d got=%h required=%h", i, rd, 8'h10 + 8'(i));
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int nrsp; int lat; logic [7:0] rd; logic err; int rh;
    nrsp = 0;
    if1.req_write = 1'b1; if1.req_addr = 5'd12; if1.req_wdata = 8'hEE; if1.req_valid = 1'b1;
    for (int i = 0; i < 10 && !if1.req_ready; i++) tick();
    tick();
    if1.req_valid = 1'b0;
    tick();                  // WSTB
    checks++;
    if (if1.mem_write !== 1'b1) begin failures++; $display("FAIL wstb_strobe got=%b required=1", if1.mem_write); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (if1.mem_write !== 1'b0) begin failures++; $display("FAIL async_write_drop got=%b required=0", if1.mem_write); end
    tick();
    #3 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (if1.rsp_valid) nrsp++;
    end
    checks++;
    if (nrsp !== 0) begin failures++; $display("FAIL lost_txn_rsp got=%0d required=0", nrsp); end
    do_txn(1'b0, 1'b0, 5'd12, 8'h00, lat, rd, err, rh);
    checks++;
    if (rd !== 8'h77) begin failures++; $display("FAIL prior_contents got=%h required=77", rd); end
    checks++;
    if (lat !== RD_LAT) begin failures++; $display("FAIL rd_latency_after_rst got=%0d required=%0d", lat, RD_LAT); end
  endtask

  task automatic test_rd_wait3();
    int lat; logic [7:0] rd; logic err; int rh;
    do_txn(1'b1, 1'b0, 5'd31, 8'h00, lat, rd, err, rh);
    checks++;
    if (lat !== 6) begin failures++; $display("FAIL rw3_latency got=%0d required=6", lat); end
    checks++;
    if (rd !== 8'h3C) begin failures++; $display("FAIL rw3_data got=%h required=3c", rd); end
    checks++;
    if (rh !== 3) begin failures++; $display("FAIL rw3_strobe_len got=%0d required=3", rh); end
  endtask

`ifdef MEM_BUS_INITIATOR_VERIFY_EN
  task automatic test_verify();
    int lat; logic [7:0] rd; logic err; int rh;
    stuck0 = 1'b1;
    do_txn(1'b0, 1'b1, 5'd3, 8'h01, lat, rd, err, rh);
    checks++;
    if (lat !== 6) begin failures++; $display("FAIL vfy_latency got=%0d required=6", lat); end
    checks++;
    if (err !== 1'b1 || rd !== 8'h00) begin
      failures++; $display("FAIL vfy_bad err=%b rdata=%h required err=1 rdata=00", err, rd);
    end
    do_txn(1'b0, 1'b1, 5'd4, 8'h02, lat, rd, err, rh);
    checks++;
    if (err !== 1'b0 || rd !== 8'h02) begin
      failures++; $display("FAIL vfy_good err=%b rdata=%h required err=0 rdata=02", err, rd);
    end
    stuck0 = 1'b0;
  endtask
`endif

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem1[i] = 8'h00;
      mem3[i] = 8'h00;
    end
    mem1[12] = 8'h77;
    mem3[31] = 8'h3C;
    if1.req_valid = 1'b0; if1.req_write = 1'b0; if1.req_addr = '0; if1.req_wdata = '0;
    if3.req_valid = 1'b0; if3.req_write = 1'b0; if3.req_addr = '0; if3.req_wdata = '0;
    tick(); tick();
    checks++;
    if (if1.req_ready !== 1'b0 || if1.mem_addr !== 5'd0 || if1.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL poweron_reset ready=%b addr=%0d rsp=%b required 0/0/0",
               if1.req_ready, if1.mem_addr, if1.rsp_valid);
    end
    #3 rst = 1'b0;
    tick();
    test_write_read();
    test_idle_no_activity();
    test_reset();
    test_back_to_back();
    test_reset_mid_write();
    test_rd_wait3();
`ifdef MEM_BUS_INITIATOR_VERIFY_EN
    test_verify();
`endif
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
